// File: rtl/pipe_buffer.sv
// pipe_buffer: ready/valid elastic buffer built as a circular FIFO.
//
// Parameters
//   WIDTH  - payload width in bits (>= 1)
//   DEPTH  - number of storage entries (>= 1, any value)
//   BUBBLE - payload presented whenever no entry is valid
//
// Ports
//   clk       - single clock, all state updates on the rising edge
//   rst       - synchronous active-high reset of control state
//   flush     - synchronous discard of every held entry
//   in_valid  - upstream offers in_data
//   in_ready  - buffer can accept this cycle
//   in_data   - upstream payload
//   out_valid - head entry presented on out_data
//   out_ready - downstream accepts this cycle
//   out_data  - head payload, or BUBBLE when out_valid is 0
//   count     - number of held entries
//
// in_ready depends only on registered occupancy plus flush/rst, so there is
// no combinational path from out_ready to in_ready. A full buffer therefore
// refuses a push even when the head is being popped in the same cycle.
module pipe_buffer #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  always_comb begin
    // rst and flush both mask the handshakes so nothing moves in those cycles.
    in_ready  = (count_q < CNT_FULL) && !flush && !rst;
    out_valid = (count_q != '0) && !flush && !rst;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  assign count = count_q;

  // Control state: reset has priority over flush, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only and is never reset; push is already gated by rst.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
